// File: rtl/codec_config_pkg.sv
// Shared types and constants for the audio-codec configuration sequencer.
package codec_config_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_LAUNCH,
        ST_WAIT,
        ST_GAP,
        ST_DONE,
        ST_ERROR
    } state_t;

    localparam logic [3:0] FAULT_NONE    = 4'h0;
    localparam logic [3:0] FAULT_MAX     = 4'h5;
    localparam logic [3:0] FAULT_TIMEOUT = 4'hE;
    localparam logic [3:0] FAULT_OK      = 4'hF;

    typedef struct packed {
        logic [6:0] register;
        logic [8:0] data;
    } entry_t;

    localparam int TABLE_LEN = 10;

    // Returned for any index past the end of the table: a harmless codec reset write.
    localparam entry_t ENTRY_FILL = '{register: 7'h0F, data: 9'h000};

    localparam entry_t DEFAULT_TABLE [TABLE_LEN] = '{
        '{register: 7'h0F, data: 9'h000},
        '{register: 7'h06, data: 9'h010},
        '{register: 7'h07, data: 9'h04A},
        '{register: 7'h08, data: 9'h000},
        '{register: 7'h09, data: 9'h001},
        '{register: 7'h00, data: 9'h097},
        '{register: 7'h01, data: 9'h097},
        '{register: 7'h02, data: 9'h079},
        '{register: 7'h03, data: 9'h079},
        '{register: 7'h04, data: 9'h012}
    };

    // Master fault codes 1..5 are genuine failures; 0 and F are not.
    function automatic logic is_fault(input logic [3:0] code);
        return (code != FAULT_NONE) && (code <= FAULT_MAX);
    endfunction

endpackage

// File: rtl/codec_config_rom.sv
// Combinational index-to-entry lookup into the codec register write table.
module codec_config_rom
    import codec_config_pkg::*;
(
    input  logic [5:0] i_index,
    output logic [6:0] o_register,
    output logic [8:0] o_data
);

    always_comb begin
        o_register = ENTRY_FILL.register;
        o_data     = ENTRY_FILL.data;
        for (int i = 0; i < TABLE_LEN; i++) begin
            if (i_index == 6'(i)) begin
                o_register = DEFAULT_TABLE[i].register;
                o_data     = DEFAULT_TABLE[i].data;
            end
        end
    end

endmodule

// File: rtl/codec_config_sequencer.sv
// Walks the codec write table, launching one I2C master transaction per entry
// with bounded retries, and reports completion or the first hard failure.
//
// state  | meaning
// IDLE   | after reset, waiting for i_start
// LOAD   | table entry latched onto master inputs
// LAUNCH | master held in reset for RESET_HOLD cycles
// WAIT   | transaction running; watch done/fault/timeout
// GAP    | idle spacing before next launch (advance or retry)
// DONE   | all entries written
// ERROR  | retries exhausted; index and code latched
module codec_config_sequencer
    import codec_config_pkg::*;
#(
    parameter int         N_ENTRIES      = 10,
    parameter logic [6:0] DEV_ADDR       = 7'h1A,
    parameter int         MAX_RETRIES    = 3,
    parameter int         RESET_HOLD     = 2,
    parameter int         GAP_CYCLES     = 4,
    parameter int         TIMEOUT_CYCLES = 96
) (
    input  logic       i_i2c_clk,
    input  logic       i_nrst,
    input  logic       i_start,
    output logic       o_busy,
    output logic       o_config_done,
    output logic       o_error,
    output logic [5:0] o_error_index,
    output logic [3:0] o_error_code,
    output logic       o_mst_nrst,
    output logic [6:0] o_mst_addr,
    output logic [6:0] o_mst_register,
    output logic [8:0] o_mst_data,
    output logic       o_mst_read_not_write,
    input  logic       i_mst_done,
    input  logic [3:0] i_mst_fault_code
);

    localparam logic [5:0]  LAST_INDEX  = 6'(N_ENTRIES - 1);
    localparam logic [7:0]  RETRY_LIMIT = 8'(MAX_RETRIES);
    localparam logic [15:0] HOLD_LOAD   = 16'(RESET_HOLD - 1);
    localparam logic [15:0] GAP_LOAD    = 16'(GAP_CYCLES - 1);
    localparam logic [15:0] TMO_LOAD    = 16'(TIMEOUT_CYCLES - 1);
    // The timer counts down through WAIT; the first two WAIT cycles sit above this.
    localparam logic [15:0] STALE_LIMIT = 16'(TIMEOUT_CYCLES - 3);

    state_t      state_q, state_d;
    logic [5:0]  index_q, index_d;
    logic [7:0]  retry_q, retry_d;
    logic [15:0] tmr_q, tmr_d;
    logic        last_ok_q, last_ok_d;
    logic [6:0]  reg_q, reg_d;
    logic [8:0]  data_q, data_d;
    logic [5:0]  err_index_q, err_index_d;
    logic [3:0]  err_code_q, err_code_d;

    logic        load_entry;
    logic [6:0]  rom_register;
    logic [8:0]  rom_data;
    logic        success, fault_seen, timed_out;

    codec_config_rom u_rom (
        .i_index    (index_d),
        .o_register (rom_register),
        .o_data     (rom_data)
    );

    assign success    = i_mst_done && (i_mst_fault_code == FAULT_OK);
    assign fault_seen = (tmr_q <= STALE_LIMIT) && is_fault(i_mst_fault_code);
    assign timed_out  = (tmr_q == 16'd0);

    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        retry_d     = retry_q;
        tmr_d       = tmr_q;
        last_ok_d   = last_ok_q;
        err_index_d = err_index_q;
        err_code_d  = err_code_q;
        load_entry  = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (i_start) begin
                    state_d     = ST_LOAD;
                    index_d     = 6'd0;
                    retry_d     = 8'd0;
                    err_index_d = 6'd0;
                    err_code_d  = FAULT_NONE;
                    load_entry  = 1'b1;
                end
            end
            ST_LOAD: begin
                state_d = ST_LAUNCH;
                tmr_d   = HOLD_LOAD;
            end
            ST_LAUNCH: begin
                if (tmr_q == 16'd0) begin
                    state_d = ST_WAIT;
                    tmr_d   = TMO_LOAD;
                end else begin
                    tmr_d = tmr_q - 16'd1;
                end
            end
            ST_WAIT: begin
                if (success) begin
                    state_d   = ST_GAP;
                    tmr_d     = GAP_LOAD;
                    last_ok_d = 1'b1;
                end else if (fault_seen || timed_out) begin
                    if (retry_q < RETRY_LIMIT) begin
                        state_d   = ST_GAP;
                        tmr_d     = GAP_LOAD;
                        retry_d   = retry_q + 8'd1;
                        last_ok_d = 1'b0;
                    end else begin
                        state_d     = ST_ERROR;
                        err_index_d = index_q;
                        err_code_d  = fault_seen ? i_mst_fault_code : FAULT_TIMEOUT;
                    end
                end else begin
                    tmr_d = tmr_q - 16'd1;
                end
            end
            ST_GAP: begin
                if (tmr_q != 16'd0) begin
                    tmr_d = tmr_q - 16'd1;
                end else if (!last_ok_q) begin
                    state_d    = ST_LOAD;
                    load_entry = 1'b1;
                end else if (index_q == LAST_INDEX) begin
                    state_d = ST_DONE;
                end else begin
                    state_d    = ST_LOAD;
                    index_d    = index_q + 6'd1;
                    retry_d    = 8'd0;
                    load_entry = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Master inputs change only on entry to LOAD, so they hold steady for the whole transaction.
        reg_d  = load_entry ? rom_register : reg_q;
        data_d = load_entry ? rom_data : data_q;
    end

    always_ff @(posedge i_i2c_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q     <= ST_IDLE;
            index_q     <= 6'd0;
            retry_q     <= 8'd0;
            tmr_q       <= 16'd0;
            last_ok_q   <= 1'b0;
            reg_q       <= 7'd0;
            data_q      <= 9'd0;
            err_index_q <= 6'd0;
            err_code_q  <= FAULT_NONE;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            retry_q     <= retry_d;
            tmr_q       <= tmr_d;
            last_ok_q   <= last_ok_d;
            reg_q       <= reg_d;
            data_q      <= data_d;
            err_index_q <= err_index_d;
            err_code_q  <= err_code_d;
        end
    end

    assign o_busy               = (state_q == ST_LOAD) || (state_q == ST_LAUNCH) ||
                                  (state_q == ST_WAIT) || (state_q == ST_GAP);
    assign o_config_done        = (state_q == ST_DONE);
    assign o_error              = (state_q == ST_ERROR);
    assign o_error_index        = err_index_q;
    assign o_error_code         = err_code_q;
    assign o_mst_nrst           = (state_q != ST_LAUNCH);
    assign o_mst_addr           = DEV_ADDR;
    assign o_mst_register       = reg_q;
    assign o_mst_data           = data_q;
    assign o_mst_read_not_write = 1'b0;

endmodule
